// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite-style bus bundle (AW/W/B/AR/R) for axi_lite_mem_slave.
// master drives requests and response-ready; slave drives readies and responses.
interface axi_lite_mem_slave_if #(
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32
);
  logic             awvalid;
  logic [AddrW-1:0] awaddr;
  logic             awready;
  logic             wvalid;
  logic [DataW-1:0] wdata;
  logic             wready;
  logic             bready;
  logic             bvalid;
  logic [1:0]       bresp;
  logic             arvalid;
  logic [AddrW-1:0] araddr;
  logic             arready;
  logic             rready;
  logic [DataW-1:0] rdata;
  logic             rvalid;
  logic [1:0]       rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
  );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite-style slave over a word-addressed register memory; independent write/read FSMs.
// Optional: define AXI_LITE_DECERR_EN to answer out-of-range accesses with DECERR instead of SLVERR.
module axi_lite_mem_slave #(
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32
) (
  input  logic                  aclk_i,
  input  logic                  arst_i,
  axi_lite_mem_slave_if.slave   bus_io
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [1:0] RespOkay = 2'b00;
`ifdef AXI_LITE_DECERR_EN
  localparam logic [1:0] RespOor  = 2'b11;
`else
  localparam logic [1:0] RespOor  = 2'b10;
`endif

  typedef enum logic [2:0] {WIdle, WAddr, WData, WWack, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData} r_state_e;

  w_state_e w_state_q;
  r_state_e r_state_q;

  logic [AddrW-1:0] awaddr_q;
  logic [AddrW-1:0] araddr_q;
  logic             awready_q;
  logic             wready_q;
  logic             bvalid_q;
  logic [1:0]       bresp_q;
  logic             arready_q;
  logic             rvalid_q;
  logic [1:0]       rresp_q;
  logic [DataW-1:0] rdata_q;

  logic [DataW-1:0] mem_q [Depth];

  logic            w_in_range;
  logic            r_in_range;
  logic [IdxW-1:0] w_idx;
  logic [IdxW-1:0] r_idx;
  logic            mem_we;

  // Address is a word index, so range check is against the full captured address.
  assign w_in_range = (awaddr_q < AddrW'(Depth));
  assign r_in_range = (araddr_q < AddrW'(Depth));
  assign w_idx      = awaddr_q[IdxW-1:0];
  assign r_idx      = araddr_q[IdxW-1:0];
  assign mem_we     = (w_state_q == WData) && bus_io.wvalid && w_in_range;

  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[w_idx] <= bus_io.wdata;
    end
  end

  // Write channel: AW accept, W accept (commit on the same edge), then hold B until bready.
  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      w_state_q <= WIdle;
      awaddr_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
    end else begin
      case (w_state_q)
        WIdle: begin
          if (bus_io.awvalid) begin
            awaddr_q  <= bus_io.awaddr;
            awready_q <= 1'b1;
            w_state_q <= WAddr;
          end
        end
        WAddr: begin
          awready_q <= 1'b0;
          w_state_q <= WData;
        end
        WData: begin
          if (bus_io.wvalid) begin
            wready_q  <= 1'b1;
            w_state_q <= WWack;
          end
        end
        WWack: begin
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b1;
          bresp_q   <= w_in_range ? RespOkay : RespOor;
          w_state_q <= WResp;
        end
        WResp: begin
          if (bus_io.bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            w_state_q <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  // Read channel: data is sampled from memory on the edge leaving RAddr, so a
  // write committing on that same edge is not visible to this read.
  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state_q <= RIdle;
      araddr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        RIdle: begin
          if (bus_io.arvalid) begin
            araddr_q  <= bus_io.araddr;
            arready_q <= 1'b1;
            r_state_q <= RAddr;
          end
        end
        RAddr: begin
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rdata_q   <= r_in_range ? mem_q[r_idx] : '0;
          rresp_q   <= r_in_range ? RespOkay : RespOor;
          r_state_q <= RData;
        end
        RData: begin
          if (bus_io.rready) begin
            rvalid_q  <= 1'b0;
            rresp_q   <= RespOkay;
            rdata_q   <= '0;
            r_state_q <= RIdle;
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  assign bus_io.awready = awready_q;
  assign bus_io.wready  = wready_q;
  assign bus_io.bvalid  = bvalid_q;
  assign bus_io.bresp   = bresp_q;
  assign bus_io.arready = arready_q;
  assign bus_io.rvalid  = rvalid_q;
  assign bus_io.rresp   = rresp_q;
  assign bus_io.rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Self-checking bench for axi_lite_mem_slave: vector table driven through bus tasks,
// response scoreboard queues, plus hand-built reset and same-edge concurrency sequences.
module tb_axi_lite_mem_slave;

`ifdef AXI_LITE_DECERR_EN
  localparam logic [1:0] Oor = 2'b11;
`else
  localparam logic [1:0] Oor = 2'b10;
`endif
  localparam logic [1:0] Ok = 2'b00;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;  // write data, or expected read data
    logic [1:0]  resp;
    int          bp;    // cycles of response backpressure
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic aclk = 1'b0;
  logic arst = 1'b1;

  int checks = 0;
  int errors = 0;

  rd_exp_t    rd_q[$];
  logic [1:0] wr_q[$];
  vec_t       vecs[13];

  axi_lite_mem_slave_if #(.AddrW(32), .DataW(32)) bus ();

  axi_lite_mem_slave #(
    .Depth(256),
    .AddrW(32),
    .DataW(32)
  ) dut (
    .aclk_i (aclk),
    .arst_i (arst),
    .bus_io (bus)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, {bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready, bus.rvalid,
               bus.rresp, bus.rdata}, 64'd0);
  endtask

  task automatic pop_rd(output rd_exp_t e);
    if (rd_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rd_scoreboard: got unexpected read response, expected none");
      e = '0;
    end else begin
      e = rd_q.pop_front();
    end
  endtask

  task automatic pop_wr(output logic [1:0] r);
    if (wr_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL wr_scoreboard: got unexpected write response, expected none");
      r = 2'b00;
    end else begin
      r = wr_q.pop_front();
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input int bp);
    logic [1:0] er;
    bus.awvalid = 1'b1;
    bus.awaddr  = addr;
    wr_q.push_back(resp);
    step();
    chk("awready_latency", bus.awready, 1);
    bus.awvalid = 1'b0;
    step();
    chk("awready_pulse", bus.awready, 0);
    bus.wvalid = 1'b1;
    bus.wdata  = data;
    step();
    chk("wready_latency", bus.wready, 1);
    bus.wvalid = 1'b0;
    step();
    chk("wready_pulse", bus.wready, 0);
    chk("bvalid", bus.bvalid, 1);
    pop_wr(er);
    chk("bresp", bus.bresp, er);
    for (int i = 0; i < bp; i++) begin
      step();
      chk("bvalid_hold", bus.bvalid, 1);
      chk("bresp_hold", bus.bresp, er);
    end
    bus.bready = 1'b1;
    step();
    chk("bvalid_clear", bus.bvalid, 0);
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, input int bp);
    rd_exp_t e;
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    rd_q.push_back('{data: data, resp: resp});
    step();
    chk("arready_latency", bus.arready, 1);
    bus.arvalid = 1'b0;
    step();
    chk("arready_pulse", bus.arready, 0);
    chk("rvalid", bus.rvalid, 1);
    pop_rd(e);
    chk("rdata", bus.rdata, e.data);
    chk("rresp", bus.rresp, e.resp);
    for (int i = 0; i < bp; i++) begin
      step();
      chk("rvalid_hold", bus.rvalid, 1);
      chk("rdata_hold", bus.rdata, e.data);
    end
    bus.rready = 1'b1;
    step();
    chk("rvalid_clear", bus.rvalid, 0);
    bus.rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rd_exp_t    e;
    logic [1:0] er;

    vecs[0]  = '{wr: 0, addr: 32'h10,       data: 32'h0000_0000, resp: Ok,  bp: 0};
    vecs[1]  = '{wr: 1, addr: 32'h87,       data: 32'h0000_0001, resp: Ok,  bp: 0};
    vecs[2]  = '{wr: 0, addr: 32'h87,       data: 32'h0000_0001, resp: Ok,  bp: 0};
    vecs[3]  = '{wr: 1, addr: 32'h100,      data: 32'hDEAD_BEEF, resp: Oor, bp: 5};
    vecs[4]  = '{wr: 0, addr: 32'h100,      data: 32'h0000_0000, resp: Oor, bp: 5};
    vecs[5]  = '{wr: 0, addr: 32'h0,        data: 32'h0000_0000, resp: Ok,  bp: 0};
    vecs[6]  = '{wr: 1, addr: 32'hFF,       data: 32'h1234_5678, resp: Ok,  bp: 1};
    vecs[7]  = '{wr: 0, addr: 32'hFF,       data: 32'h1234_5678, resp: Ok,  bp: 0};
    vecs[8]  = '{wr: 1, addr: 32'h0,        data: 32'hCAFE_F00D, resp: Ok,  bp: 0};
    vecs[9]  = '{wr: 0, addr: 32'h0,        data: 32'hCAFE_F00D, resp: Ok,  bp: 2};
    vecs[10] = '{wr: 0, addr: 32'hFFFF_FFFF, data: 32'h0000_0000, resp: Oor, bp: 0};
    vecs[11] = '{wr: 1, addr: 32'h87,       data: 32'h55AA_55AA, resp: Ok,  bp: 0};
    vecs[12] = '{wr: 0, addr: 32'h87,       data: 32'h55AA_55AA, resp: Ok,  bp: 5};

    bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0;
    bus.bready  = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;

    #2;
    chk_idle_outputs("reset_outputs");
    repeat (2) @(posedge aclk);
    #3 arst = 1'b0;
    step();
    chk_idle_outputs("post_reset_outputs");

    foreach (vecs[i]) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].resp, vecs[i].bp);
      else            do_read(vecs[i].addr, vecs[i].data, vecs[i].resp, vecs[i].bp);
    end

    // Reset while a write response is pending: bvalid must drop without a clock edge.
    bus.awvalid = 1'b1; bus.awaddr = 32'h33;
    step();
    bus.awvalid = 1'b0;
    step();
    bus.wvalid = 1'b1; bus.wdata = 32'h1111_1111;
    step();
    bus.wvalid = 1'b0;
    step();
    chk("midop_bvalid_before", bus.bvalid, 1);
    #2 arst = 1'b1;
    #1;
    chk("midop_bvalid_async", bus.bvalid, 0);
    chk_idle_outputs("midop_reset_outputs");
    repeat (2) @(posedge aclk);
    #3 arst = 1'b0;
    step();
    do_read(32'h33, 32'h0, Ok, 0);
    do_read(32'h87, 32'h0, Ok, 0);

    // Concurrent write/read of 0x05: read captures on the edge before the commit.
    bus.awvalid = 1'b1; bus.awaddr = 32'h05;
    bus.arvalid = 1'b1; bus.araddr = 32'h05;
    rd_q.push_back('{data: 32'h0, resp: Ok});
    wr_q.push_back(Ok);
    step();
    chk("conc_awready", bus.awready, 1);
    chk("conc_arready", bus.arready, 1);
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'hA5A5_A5A5;
    step();
    chk("conc_rvalid", bus.rvalid, 1);
    pop_rd(e);
    chk("conc_rdata", bus.rdata, e.data);
    chk("conc_rresp", bus.rresp, e.resp);
    step();
    chk("conc_wready", bus.wready, 1);
    bus.wvalid = 1'b0;
    step();
    chk("conc_bvalid", bus.bvalid, 1);
    pop_wr(er);
    chk("conc_bresp", bus.bresp, er);
    bus.bready = 1'b1; bus.rready = 1'b1;
    step();
    chk("conc_done", {bus.bvalid, bus.rvalid}, 0);
    bus.bready = 1'b0; bus.rready = 1'b0;
    do_read(32'h05, 32'hA5A5_A5A5, Ok, 0);

    // Same-edge commit and read capture at 0x06: read must see the old word.
    do_write(32'h06, 32'h1111_2222, Ok, 0);
    bus.awvalid = 1'b1; bus.awaddr = 32'h06;
    wr_q.push_back(Ok);
    step();
    bus.awvalid = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = 32'h06;
    rd_q.push_back('{data: 32'h1111_2222, resp: Ok});
    step();
    chk("same_arready", bus.arready, 1);
    bus.arvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'h3333_4444;
    step();
    chk("same_wready", bus.wready, 1);
    chk("same_rvalid", bus.rvalid, 1);
    pop_rd(e);
    chk("same_rdata_old", bus.rdata, e.data);
    bus.wvalid = 1'b0;
    step();
    pop_wr(er);
    chk("same_bresp", {bus.bvalid, bus.bresp}, {1'b1, er});
    bus.bready = 1'b1; bus.rready = 1'b1;
    step();
    chk("same_done", {bus.bvalid, bus.rvalid}, 0);
    bus.bready = 1'b0; bus.rready = 1'b0;
    do_read(32'h06, 32'h3333_4444, Ok, 0);

    chk("scoreboard_drained", rd_q.size() + wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_slave.md
Name: axi_lite_mem_slave

Overview:
- Single-clock AXI4-Lite-style slave fronting a word-addressed 32-bit register memory.
- Independent write (AW/W/B) and read (AR/R) channel state machines.
- Each handshake ready is a registered one-cycle pulse.
- Sits behind a bus master or interconnect as a simple scratch memory / register bank.

Parameters:
- DEPTH, 256, number of 32-bit words; word index = address value (not byte address).
- ADDR_W, 32, width of awaddr/araddr.
- DATA_W, 32, width of wdata/rdata.

Ports:
- aclk  input  1  clock, all logic on rising edge.
- arst  input  1  reset; one clock; reset is asynchronous and active-high.
- awvalid  input  1  write address valid.
- awaddr  input  32  write word address.
- awready  output  1  write address accepted pulse.
- wvalid  input  1  write data valid.
- wdata  input  32  write data.
- wready  output  1  write data accepted pulse.
- bready  input  1  master ready for write response.
- bvalid  output  1  write response valid.
- bresp  output  2  write response.
- arvalid  input  1  read address valid.
- araddr  input  32  read word address.
- arready  output  1  read address accepted pulse.
- rready  input  1  master ready for read data.
- rdata  output  32  read data.
- rvalid  output  1  read data valid.
- rresp  output  2  read response.

Behaviour:
- Reset (arst=1, asynchronous):
  - All outputs = 0; both FSMs return to IDLE.
  - All memory words = 0; captured addresses = 0.
  - Reset mid-transaction aborts it; a pending write is not committed.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_WACK, W_RESP.
  - W_IDLE: edge with awvalid=1 captures awaddr -> W_ADDR.
  - W_ADDR: awready=1 for exactly this cycle -> W_DATA.
  - W_DATA: edge with wvalid=1 -> W_WACK. If the captured address < DEPTH, mem[addr] <= wdata at this edge; otherwise no write.
  - W_WACK: wready=1 for exactly this cycle -> W_RESP.
  - W_RESP: bvalid=1, bresp held stable. Edge with bready=1 -> W_IDLE, bvalid=0.
  - bresp = 2'b00 (OKAY) if in range, else 2'b10 (SLVERR).
  - wvalid before address acceptance is ignored until W_DATA.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: edge with arvalid=1 captures araddr -> R_ADDR.
  - R_ADDR: arready=1 for exactly this cycle. At exit edge, rdata <= mem[addr] (0 if out of range) -> R_DATA.
  - R_DATA: rvalid=1; rdata/rresp stable until an edge with rready=1 -> R_IDLE, rvalid=0.
  - rresp = OKAY in range, SLVERR otherwise.
- Latency: ready pulse appears one cycle after valid is first sampled.
- Masters hold valid until they observe the ready pulse fall; any valid still high in IDLE starts a new transaction.
- Read and write FSMs run concurrently. If a write commit and a read data capture to the same address occur on the same edge, the read returns the old value.
- One outstanding transaction per channel; no bursts, no IDs, no strobes (full-word writes).

Optional Feature:
- Macro AXI_LITE_DECERR_EN.
- Defined: out-of-range accesses return 2'b11 (DECERR) on bresp/rresp.
- Undefined: out-of-range accesses return 2'b10 (SLVERR).
- In-range behaviour is identical in both builds.

Test Plan:
- Reset: arst=1 then 0 -> all outputs 0; read of address 0x10 -> rdata=0x00000000, rresp=00.
- Write 0x87 <- 0x00000001:
  - awready pulses 1 cycle after awvalid.
  - wready pulses 1 cycle after wvalid.
  - bvalid=1, bresp=00, held until bready.
  - Then read 0x87 -> arready pulse, rvalid=1, rdata=0x00000001, rresp=00.
- Out of range: write 0x100 <- 0xDEADBEEF -> bresp=10 (11 with macro); read 0x100 -> rdata=0, rresp=10 (11 with macro).
- Backpressure: bready low 5 cycles after bvalid -> bvalid and bresp stable; rready low 5 cycles -> rvalid and rdata stable.
- Reset mid-op: assert arst while bvalid=1 -> bvalid=0 immediately (asynchronous); after release, read of that address -> 0.
- Concurrency: write 0x05 <- 0xA5A5A5A5 concurrent with read 0x05 -> read completes with old value 0 or new value depending on commit edge, per the same-edge rule; both responses OKAY.
